rf_wb_arbiter: RTL

- Shares the single register-file write port (A3/WD3/WE) between NUM_REQ writeback sources, e.g. ALU, load unit and CSR/debug.
- Each source uses a valid/ready handshake. Arbitration is round-robin with one grant per cycle.
- The granted write passes through one registered output stage that drives the register file directly.
- A pending-register mask is exported so that issue logic can stall reads of registers that are about to be written.

---
 rtl/rf_wb_arbiter_if.sv | 27 ++
 rtl/rf_wb_arbiter.sv | 98 +++++++++
 2 files changed

// File: rtl/rf_wb_arbiter_if.sv
// Writeback bus between NUM_REQ producers and the shared register-file write port.
// master = requester/regfile side, slave = arbiter side.
interface rf_wb_arbiter_if #(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = 32
);
  logic                             hold;
  logic [NUM_REQ-1:0]               req_valid;
  logic [NUM_REQ-1:0][ADDR_W-1:0]   req_addr;
  logic [NUM_REQ-1:0][DATA_W-1:0]   req_data;
  logic [NUM_REQ-1:0]               req_ready;
  logic                             rf_we;
  logic [ADDR_W-1:0]                rf_a3;
  logic [DATA_W-1:0]                rf_wd3;
  logic [2**ADDR_W-1:0]             pend_mask;

  modport master (
    output hold, req_valid, req_addr, req_data,
    input  req_ready, rf_we, rf_a3, rf_wd3, pend_mask
  );

  modport slave (
    input  hold, req_valid, req_addr, req_data,
    output req_ready, rf_we, rf_a3, rf_wd3, pend_mask
  );
endinterface

// File: rtl/rf_wb_arbiter.sv
// Round-robin arbiter sharing one register-file write port, with a registered output stage
// and a pending-register mask. Optional output-stage forwarding under RF_WB_FWD_EN.
module rf_wb_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = 32
) (
  input  logic                clk,
  input  logic                reset,
  rf_wb_arbiter_if.slave      bus
`ifdef RF_WB_FWD_EN
  ,
  input  logic [ADDR_W-1:0]   fwd_a1,
  input  logic [ADDR_W-1:0]   fwd_a2,
  output logic                fwd_hit1,
  output logic                fwd_hit2,
  output logic [DATA_W-1:0]   fwd_data
`endif
);
  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int NREG  = 2**ADDR_W;

  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] a3_q, a3_d;
  logic [DATA_W-1:0] wd3_q, wd3_d;

  logic [NUM_REQ-1:0] gnt;
  logic               gnt_any;
  logic [PTR_W-1:0]   gnt_idx;
  int                 idx;

  // Scan from ptr with wraparound; the first valid index wins. Reset gates grants.
  always_comb begin
    gnt     = '0;
    gnt_any = 1'b0;
    gnt_idx = '0;
    idx     = 0;
    for (int o = 0; o < NUM_REQ; o++) begin
      idx = (int'(ptr_q) + o) % NUM_REQ;
      if (!gnt_any && reset && !bus.hold && bus.req_valid[idx]) begin
        gnt_any = 1'b1;
        gnt_idx = PTR_W'(idx);
      end
    end
    if (gnt_any) gnt[gnt_idx] = 1'b1;
  end

  always_comb begin
    ptr_d = ptr_q;
    we_d  = 1'b0;
    a3_d  = a3_q;
    wd3_d = wd3_q;
    if (gnt_any) begin
      ptr_d = (gnt_idx == PTR_W'(NUM_REQ-1)) ? '0 : gnt_idx + 1'b1;
      // x0 still consumes the slot but must never reach the register file
      we_d  = |bus.req_addr[gnt_idx];
      a3_d  = bus.req_addr[gnt_idx];
      wd3_d = bus.req_data[gnt_idx];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_q <= '0;
      we_q  <= 1'b0;
      a3_q  <= '0;
      wd3_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      we_q  <= we_d;
      a3_q  <= a3_d;
      wd3_q <= wd3_d;
    end
  end

  logic [NREG-1:0] pend;

  always_comb begin
    pend = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (bus.req_valid[i]) pend[bus.req_addr[i]] = 1'b1;
    if (we_q) pend[a3_q] = 1'b1;
    pend[0] = 1'b0;
  end

  assign bus.pend_mask = reset ? pend : '0;
  assign bus.req_ready = gnt;
  assign bus.rf_we     = we_q;
  assign bus.rf_a3     = a3_q;
  assign bus.rf_wd3    = wd3_q;

`ifdef RF_WB_FWD_EN
  assign fwd_hit1 = we_q && (a3_q == fwd_a1) && (|fwd_a1);
  assign fwd_hit2 = we_q && (a3_q == fwd_a2) && (|fwd_a2);
  assign fwd_data = wd3_q;
`endif
endmodule
